mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter WAIT_W, default 4, SHALL set the memory-wait timeout counter width; timeout limit = 2^WAIT_W-1 cycles.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 opcode  in  6  SHALL carry instruction [31:26] from the instruction register.
REQ-005 zero  in  1  SHALL be the ALU zero flag; used only externally via pc_write_cond.
REQ-006 mem_ready  in  1  SHALL indicate the memory access completes this cycle.
REQ-007 Outputs, all width 1: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, err.
REQ-008 Outputs, width 2: alu_src_b, alu_op (00 add, 01 branch compare, 10 funct-decoded), pc_source (00 ALU, 01 ALUOut, 10 jump); state_o width 4, debug copy of current state.

Function
REQ-009 Control SHALL be a Moore FSM; outputs decode current state only, except ir_write and pc_write in FETCH, which equal mem_ready.
REQ-010 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, ERR.
REQ-011 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; stay until mem_ready, then DECODE.
REQ-012 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 100011/101011 MEM_ADDR, 000000 EXEC, 000100 BRANCH, 000010 JUMP, 001000 ADDI_EX, other ERR.
REQ-013 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD for lw, MEM_WR for sw.
REQ-014 MEM_RD: mem_read=1, i_or_d=1; MEM_WR: mem_write=1, i_or_d=1; both hold until mem_ready, then MEM_WB or FETCH respectively.
REQ-015 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-016 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, next R_WB; R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, next FETCH.
REQ-017 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
REQ-018 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-019 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00, next ADDI_WB; ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, next FETCH.
REQ-020 Any output not listed for a state SHALL be 0.
REQ-021 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and on mem_ready, increment each cycle waited; reaching limit with mem_ready=0 SHALL enter ERR next cycle.
REQ-022 mem_ready=1 on the limit cycle SHALL take priority; normal transition, no ERR.
REQ-023 ERR SHALL be absorbing: err=1, all other outputs 0, exit only by reset.

Reset
REQ-024 rst_n low SHALL immediately force state FETCH, counter 0, err 0, and every output 0 (mem_read included) while asserted.
REQ-025 Reset mid-access SHALL abandon the access; first post-reset cycle restarts FETCH with counter 0.

Configuration
REQ-026 Macro MC_ADDI_EN defined: ADDI_EX/ADDI_WB present, opcode 001000 supported.
REQ-027 MC_ADDI_EN undefined: both states omitted; opcode 001000 SHALL go to ERR from DECODE.

Structure
REQ-028 Package mc_pkg SHALL hold the state enum, opcode constants, and alu_op / pc_source / alu_src_b encodings.
REQ-029 Timeout counter SHALL be sub-module mc_wait_timer (inputs clear/inc, output expired).

Verification
REQ-030 lw, mem_ready=1: FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; back in FETCH on cycle 6; reg_write=1 only in MEM_WB.
REQ-031 R-type, sw, beq, j with mem_ready=1: FETCH reached after 4, 4, 3, 3 states; beq shows pc_write_cond=1, alu_op=01.
REQ-032 mem_ready low 3 cycles in FETCH: mem_read held, ir_write=0 until ready cycle, then DECODE.
REQ-033 mem_ready low 15 cycles (WAIT_W=4) in MEM_RD: ERR, err=1; ready on 15th cycle instead: MEM_WB, err=0.
REQ-034 opcode 111111 -> ERR after DECODE; opcode 001000 -> ADDI_EX with MC_ADDI_EN, ERR without.
REQ-035 rst_n pulsed low during MEM_WR: mem_write drops asynchronously; FETCH after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// MC_ADDI_EN adds the ADDI_EX/ADDI_WB states when defined.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
`ifdef MC_ADDI_EN
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11,
`endif
    ST_ERR      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       err;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that sit waiting on mem_ready and are guarded by the timeout.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Instruction/memory-status inputs and datapath control outputs of mc_control.
interface mc_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic       err;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state_o;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, err,
           alu_src_b, alu_op, pc_source, state_o
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, err,
           alu_src_b, alu_op, pc_source, state_o
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory-wait timeout counter; expired flags the last waited cycle before the
// count reaches 2^WAIT_W-1.
module mc_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam logic [WAIT_W-1:0] LIMIT = '1;

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // This waited cycle is the one that brings the count to the limit.
  assign expired = inc && (r_count == LIMIT - 1'b1);
endmodule

// File: rtl/mc_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with memory-wait timeout.
// MC_ADDI_EN enables the addi instruction (otherwise opcode 001000 is illegal).
module mc_control
  import mc_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.slave  bus
);
  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;
  logic   w_wait_st;
  logic   w_clear;
  logic   w_inc;
  logic   w_expired;
  logic   w_unused_zero;

  assign w_unused_zero = bus.zero;

  assign w_wait_st = is_wait_state(r_state);
  assign w_clear   = !w_wait_st || bus.mem_ready;
  assign w_inc     = w_wait_st && !bus.mem_ready;

  mc_wait_timer #(.WAIT_W(WAIT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .inc     (w_inc),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRC_B_FOUR;
        w_ctrl.alu_op    = ALU_OP_ADD;
        w_ctrl.pc_source = PC_SRC_ALU;
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready)  w_next = ST_DECODE;
        else if (w_expired) w_next = ST_ERR;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_b = SRC_B_IMM_SH;
        w_ctrl.alu_op    = ALU_OP_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = ST_MEM_ADDR;
          OP_RTYPE:     w_next = ST_EXEC;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = ST_ADDI_EX;
`endif
          default:      w_next = ST_ERR;
        endcase
      end
      ST_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
        w_next = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready)  w_next = ST_MEM_WB;
        else if (w_expired) w_next = ST_ERR;
      end
      ST_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
        if (bus.mem_ready)  w_next = ST_FETCH;
        else if (w_expired) w_next = ST_ERR;
      end
      ST_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next = ST_FETCH;
      end
      ST_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRC_B_REG;
        w_ctrl.alu_op    = ALU_OP_FUNCT;
        w_next = ST_R_WB;
      end
      ST_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next = ST_FETCH;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRC_B_REG;
        w_ctrl.alu_op        = ALU_OP_BRANCH;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PC_SRC_ALUOUT;
        w_next = ST_FETCH;
      end
      ST_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PC_SRC_JUMP;
        w_next = ST_FETCH;
      end
`ifdef MC_ADDI_EN
      ST_ADDI_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
        w_next = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_next = ST_FETCH;
      end
`endif
      ST_ERR: begin
        w_ctrl.err = 1'b1;
      end
      default: begin
        w_next = ST_ERR;
      end
    endcase
  end

  // Outputs are forced low combinationally so an access stops the moment rst_n falls.
  assign w_out = rst_n ? w_ctrl : '0;

  assign bus.pc_write      = w_out.pc_write;
  assign bus.pc_write_cond = w_out.pc_write_cond;
  assign bus.i_or_d        = w_out.i_or_d;
  assign bus.mem_read      = w_out.mem_read;
  assign bus.mem_write     = w_out.mem_write;
  assign bus.ir_write      = w_out.ir_write;
  assign bus.mem_to_reg    = w_out.mem_to_reg;
  assign bus.reg_dst       = w_out.reg_dst;
  assign bus.reg_write     = w_out.reg_write;
  assign bus.alu_src_a     = w_out.alu_src_a;
  assign bus.err           = w_out.err;
  assign bus.alu_src_b     = w_out.alu_src_b;
  assign bus.alu_op        = w_out.alu_op;
  assign bus.pc_source     = w_out.pc_source;
  assign bus.state_o       = r_state;
endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: instruction-level reference model pushes
// per-cycle expectations; a negedge monitor pops and compares.
module tb_mc_control;
  import mc_pkg::*;

  localparam int WAIT_W = 4;
  localparam int LIMIT  = (1 << WAIT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control #(.WAIT_W(WAIT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    state_t      st;
    logic [16:0] ctl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [5:0] op_tab [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b000010, 6'b001000, 6'b111111};

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [16:0] act_vec();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.err, bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  // Control outputs each state must show, straight from the state table.
  function automatic logic [16:0] exp_out(state_t s, bit rdy);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, sa = 0, er = 0;
    logic [1:0] srcb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (s)
      ST_FETCH:    begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE:   begin srcb = 2'b11; end
      ST_MEM_ADDR: begin sa = 1; srcb = 2'b10; end
      ST_MEM_RD:   begin mrd = 1; iord = 1; end
      ST_MEM_WR:   begin mwr = 1; iord = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_EXEC:     begin sa = 1; aop = 2'b10; end
      ST_R_WB:     begin rw = 1; rdst = 1; end
      ST_BRANCH:   begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      ST_JUMP:     begin pcw = 1; psrc = 2'b10; end
`ifdef MC_ADDI_EN
      ST_ADDI_EX:  begin sa = 1; srcb = 2'b10; end
      ST_ADDI_WB:  begin rw = 1; end
`endif
      ST_ERR:      begin er = 1; end
      default:     begin end
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, er, srcb, aop, psrc};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp += 2;
      if (bus.state_o !== mon_e.st) begin
        n_bad++;
        $display("FAIL state_o t=%0t got=%0d exp=%0d", $time, bus.state_o, mon_e.st);
      end
      if (act_vec() !== mon_e.ctl) begin
        n_bad++;
        $display("FAIL ctrl t=%0t state=%0d got=%b exp=%b", $time, mon_e.st, act_vec(), mon_e.ctl);
      end
    end
  end

  // Each call covers one clock cycle; entered and left 1 ns after a rising edge.
  task automatic step(state_t s, bit rdy);
    exp_t e;
    bus.mem_ready = rdy;
    bus.zero      = rb();
    e.st  = s;
    e.ctl = exp_out(s, rdy);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(state_t s, int w, output bit timed_out);
    timed_out = 1'b0;
    for (int k = 0; k < w && k < LIMIT; k++) step(s, 1'b0);
    if (w >= LIMIT) timed_out = 1'b1;
    else            step(s, 1'b1);
  endtask

  task automatic chk_reset(string nm);
    n_cmp++;
    if (act_vec() !== 17'd0 || bus.state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL %s got ctrl=%b state=%0d exp ctrl=0 state=0", nm, act_vec(), bus.state_o);
    end
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    bus.mem_ready = rb();
    #1;
    chk_reset("rst_async");
    @(posedge clk);
    #1;
    chk_reset("rst_hold");
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(logic [5:0] op, int wf, int wm);
    bit e;
    bus.opcode = op;
    wait_state(ST_FETCH, wf, e);
    if (!e) begin
      step(ST_DECODE, rb());
      case (op)
        6'b100011: begin
          step(ST_MEM_ADDR, rb());
          wait_state(ST_MEM_RD, wm, e);
          if (!e) step(ST_MEM_WB, rb());
        end
        6'b101011: begin
          step(ST_MEM_ADDR, rb());
          wait_state(ST_MEM_WR, wm, e);
        end
        6'b000000: begin step(ST_EXEC, rb()); step(ST_R_WB, rb()); end
        6'b000100: step(ST_BRANCH, rb());
        6'b000010: step(ST_JUMP, rb());
`ifdef MC_ADDI_EN
        6'b001000: begin step(ST_ADDI_EX, rb()); step(ST_ADDI_WB, rb()); end
`endif
        default:   e = 1'b1;
      endcase
    end
    if (e) begin
      repeat (2) step(ST_ERR, rb());
      do_reset();
    end
    $display("instr op=%b fetch_wait=%0d mem_wait=%0d -> %s", op, wf, wm, e ? "ERR+reset" : "FETCH");
  endtask

  task automatic reset_mid_write();
    bit e;
    bus.opcode = 6'b101011;
    wait_state(ST_FETCH, 0, e);
    step(ST_DECODE, rb());
    step(ST_MEM_ADDR, rb());
    step(ST_MEM_WR, 1'b0);
    step(ST_MEM_WR, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL mw_before_rst got=%b exp=1", bus.mem_write);
    end
    do_reset();
    $display("instr sw reset during MEM_WR -> FETCH");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [5:0] op;
    int wf, wm;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(6'b100011, 0, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b100011, 3, 0);
    run_instr(6'b100011, 0, LIMIT);
    run_instr(6'b100011, 0, LIMIT - 1);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b101011, 0, LIMIT);
    run_instr(6'b101011, 1, LIMIT - 1);
    run_instr(6'b000000, LIMIT - 1, 0);
    run_instr(6'b000100, LIMIT, 0);
    reset_mid_write();
    run_instr(6'b000010, 0, 0);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 7);
      if (k == 7) op = 6'($urandom);
      else        op = op_tab[k];
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(LIMIT - 2, LIMIT + 1) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 5) == 0) ? $urandom_range(LIMIT - 2, LIMIT + 1) : $urandom_range(0, 3);
      run_instr(op, wf, wm);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
